multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- It drives the enables and mux selects for the PC, the instruction register, unified memory, the register file write port and the ALU.
- It is the sequential replacement for the single-cycle opcode decoder.
- It also handles memory wait-states through a ready handshake, flags illegal opcodes and counts retired instructions.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ready in any memory state; 0 disables the timeout.
- CNT_W, 32, width of instr_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  6  instruction[31:26] taken from the instruction register.
- mem_ready  input  1  memory completes the current read or write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load when the ALU zero flag is set (beq).
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  write-data select: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  destination select: 0 = rt, 1 = rd.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  output  2  00 = add, 01 = sub, 10 = funct.
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state encoding, for debug and bench use.
- illegal_op  output  1  sticky; set on an undecodable opcode.
- mem_timeout  output  1  sticky; set when a memory wait exceeds TIMEOUT.
- instr_count  output  CNT_W  retired-instruction counter.

Behaviour:
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, j = 000010.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- Reset (reset == 0, asynchronous):
  - state = FETCH; wait counter = 0; illegal_op = 0; mem_timeout = 0; instr_count = 0.
  - All control outputs are forced to 0 while reset is low.
- All control outputs are decoded from state; they are 0 unless listed below.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
  - ir_write and pc_write are asserted only in the cycle mem_ready = 1; FETCH then moves to DECODE.
  - Otherwise FETCH holds and the wait counter increments.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00.
  - Next state: lw/sw -> MEMADR, R -> RTEX, beq -> BEQEX, addi -> ADDIEX, j -> JEX.
  - Any other opcode: set illegal_op and go to FETCH; the instruction is not counted.
- MEMADR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD:
  - Outputs: mem_read = 1, i_or_d = 1.
  - Holds until mem_ready = 1, then goes to MEMWB.
- MEMWB:
  - Outputs: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
  - Next state FETCH; retire.
- MEMWR:
  - Outputs: mem_write = 1, i_or_d = 1.
  - Holds until mem_ready = 1, then goes to FETCH; retire.
- RTEX:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - Next state RTWB.
- RTWB:
  - Outputs: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
  - Next state FETCH; retire.
- BEQEX:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_src = 01.
  - Next state FETCH; retire.
- ADDIEX:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Next state ADDIWB.
- ADDIWB:
  - Outputs: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
  - Next state FETCH; retire.
- JEX:
  - Outputs: pc_write = 1, pc_src = 10.
  - Next state FETCH; retire.
- Wait counter:
  - Clears on entry to any memory state and on every completed handshake.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with mem_ready still 0:
    - set mem_timeout;
    - abandon the access and go to FETCH;
    - no pc_write, ir_write or reg_write is issued; no retire.
- Retire:
  - instr_count increments by 1 on the clock edge leaving a terminal state into FETCH.
  - The counter wraps modulo 2^CNT_W.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction aborts immediately. No further writes occur, and the sticky flags and counter clear.
- Latency with mem_ready tied to 1:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.

Test Plan:
- mem_ready = 1; opcode = 000000 → states 0, 1, 6, 7, 0; reg_write = 1 and reg_dst = 1 only in state 7; instr_count = 1 after 4 cycles.
- opcode = 100011 with mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles with mem_read = 1 and i_or_d = 1; MEMWB has mem_to_reg = 1; total 8 cycles; count = 1.
- FETCH with mem_ready low for 2 cycles → ir_write and pc_write stay 0 until the mem_ready cycle, where both are 1 for exactly one cycle.
- opcode = 111111 → DECODE to FETCH; illegal_op = 1 and remains set; instr_count unchanged.
- TIMEOUT = 4; sw with mem_ready held 0 → after 4 cycles in MEMWR, state = 0 and mem_timeout = 1; count unchanged.
- Pull reset low asynchronously during ADDIEX → state = 0, all outputs 0 and counter = 0 without waiting for a clock edge; no reg_write is observed.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS main control FSM with memory wait-states, illegal-opcode flag and retire counter
// Ports: clk, reset (async active-low); opcode, mem_ready in; datapath enables/selects, state, illegal_op, mem_timeout, instr_count out.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, RTEX = 4'd6, RTWB = 4'd7,
                         BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam int WW = $clog2(TIMEOUT + 2);
  logic [3:0]       state_d, state_q;
  logic [WW-1:0]    wait_d, wait_q;
  logic             ill_d, ill_q, to_d, to_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             stall, expire, retire;
  always_comb begin
    stall = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !mem_ready;
    // the counter holds the number of wait cycles already spent, so the access is
    // abandoned in the TIMEOUT-th consecutive stall cycle
    expire = TIMEOUT != 0 && stall && wait_q == WW'(TIMEOUT - 1);
    wait_d = stall && !expire ? wait_q + WW'(1) : '0;
    state_d = state_q;
    retire = 1'b0;
    ill_d = ill_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE:
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = RTEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default: begin
            state_d = FETCH;
            ill_d = 1'b1;
          end
        endcase
      MEMADR: state_d = opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR: begin
        state_d = mem_ready ? FETCH : MEMWR;
        retire = mem_ready;
      end
      RTEX:   state_d = RTWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, RTWB, BEQEX, ADDIWB, JEX: begin
        state_d = FETCH;
        retire = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    if (expire) state_d = FETCH;
    to_d = to_q | expire;
    cnt_d = cnt_q + CNT_W'(retire);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      wait_q <= '0;
      ill_q <= 1'b0;
      to_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      ill_q <= ill_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
    end
  end
  // control outputs decode from state; reset gates them so nothing is driven while held
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_src = 2'b00;
    if (reset)
      case (state_q)
        FETCH: begin
          mem_read = 1'b1;
          alu_src_b = 2'b01;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: alu_src_b = 2'b11;
        MEMADR, ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_read = 1'b1;
          i_or_d = 1'b1;
        end
        MEMWB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_write = 1'b1;
          i_or_d = 1'b1;
        end
        RTEX: begin
          alu_src_a = 1'b1;
          alu_op = 2'b10;
        end
        RTWB: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
        end
        BEQEX: begin
          alu_src_a = 1'b1;
          alu_op = 2'b01;
          pc_write_cond = 1'b1;
          pc_src = 2'b01;
        end
        ADDIWB: reg_write = 1'b1;
        JEX: begin
          pc_write = 1'b1;
          pc_src = 2'b10;
        end
        default: ;
      endcase
  end
  assign state = state_q;
  assign illegal_op = ill_q;
  assign mem_timeout = to_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
module tb_multicycle_control;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
  logic        clk = 1'b0, reset = 1'b0, mem_ready = 1'b0;
  logic [5:0]  opcode = '0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op, mem_timeout;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic [31:0] instr_count;
  int n_cmp = 0, n_err = 0;
  multicycle_control #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic nx(input logic rdy, input logic [5:0] op);
    @(negedge clk);
    mem_ready = rdy;
    opcode = op;
    #1;
  endtask
  initial begin
    #3;
    chk("rst_state", state, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_alu_src_b", alu_src_b, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_illegal", illegal_op, 0);
    @(negedge clk);
    reset = 1'b1;
    nx(1, R);
    chk("r_fetch_state", state, 0);
    chk("r_fetch_ir_write", ir_write, 1);
    chk("r_fetch_pc_write", pc_write, 1);
    chk("r_fetch_alu_src_b", alu_src_b, 1);
    nx(1, R);
    chk("r_decode_state", state, 1);
    chk("r_decode_alu_src_b", alu_src_b, 3);
    chk("r_decode_reg_write", reg_write, 0);
    nx(1, R);
    chk("r_ex_state", state, 6);
    chk("r_ex_alu_op", alu_op, 2);
    chk("r_ex_alu_src_a", alu_src_a, 1);
    chk("r_ex_reg_write", reg_write, 0);
    nx(1, R);
    chk("r_wb_state", state, 7);
    chk("r_wb_reg_write", reg_write, 1);
    chk("r_wb_reg_dst", reg_dst, 1);
    nx(0, LW);
    chk("r_done_state", state, 0);
    chk("r_done_count", instr_count, 1);
    chk("fw0_ir_write", ir_write, 0);
    chk("fw0_pc_write", pc_write, 0);
    chk("fw0_mem_read", mem_read, 1);
    nx(0, LW);
    chk("fw1_state", state, 0);
    chk("fw1_ir_write", ir_write, 0);
    nx(1, LW);
    chk("fw2_ir_write", ir_write, 1);
    chk("fw2_pc_write", pc_write, 1);
    nx(0, LW);
    chk("lw_decode_state", state, 1);
    chk("lw_decode_ir_write", ir_write, 0);
    chk("lw_decode_pc_write", pc_write, 0);
    nx(0, LW);
    chk("lw_adr_state", state, 2);
    chk("lw_adr_alu_src_b", alu_src_b, 2);
    chk("lw_adr_alu_src_a", alu_src_a, 1);
    for (int i = 0; i < 4; i++) begin
      nx(i == 3, LW);
      chk("lw_rd_state", state, 3);
      chk("lw_rd_mem_read", mem_read, 1);
      chk("lw_rd_i_or_d", i_or_d, 1);
    end
    nx(1, LW);
    chk("lw_wb_state", state, 4);
    chk("lw_wb_mem_to_reg", mem_to_reg, 1);
    chk("lw_wb_reg_write", reg_write, 1);
    chk("lw_wb_reg_dst", reg_dst, 0);
    nx(1, BAD);
    chk("lw_done_state", state, 0);
    chk("lw_done_count", instr_count, 2);
    nx(1, BAD);
    chk("ill_decode_state", state, 1);
    chk("ill_decode_flag", illegal_op, 0);
    nx(1, SW);
    chk("ill_back_state", state, 0);
    chk("ill_flag", illegal_op, 1);
    chk("ill_count", instr_count, 2);
    nx(0, SW);
    chk("sw_decode_state", state, 1);
    nx(0, SW);
    chk("sw_adr_state", state, 2);
    for (int i = 0; i < 4; i++) begin
      nx(0, SW);
      chk("sw_wr_state", state, 5);
      chk("sw_wr_mem_write", mem_write, 1);
      chk("sw_wr_timeout_clear", mem_timeout, 0);
    end
    nx(0, BEQ);
    chk("to_state", state, 0);
    chk("to_flag", mem_timeout, 1);
    chk("to_count", instr_count, 2);
    chk("to_illegal_sticky", illegal_op, 1);
    chk("to_no_ir_write", ir_write, 0);
    nx(1, BEQ);
    chk("beq_fetch_state", state, 0);
    nx(1, BEQ);
    chk("beq_decode_state", state, 1);
    nx(1, J);
    chk("beq_ex_state", state, 8);
    chk("beq_ex_pc_write_cond", pc_write_cond, 1);
    chk("beq_ex_pc_src", pc_src, 1);
    chk("beq_ex_alu_op", alu_op, 1);
    nx(1, J);
    chk("beq_done_state", state, 0);
    chk("beq_done_count", instr_count, 3);
    nx(1, J);
    chk("j_decode_state", state, 1);
    nx(1, ADDI);
    chk("j_ex_state", state, 11);
    chk("j_ex_pc_write", pc_write, 1);
    chk("j_ex_pc_src", pc_src, 2);
    nx(1, ADDI);
    chk("j_done_count", instr_count, 4);
    nx(1, ADDI);
    chk("addi_decode_state", state, 1);
    nx(1, ADDI);
    chk("addi_ex_state", state, 9);
    chk("addi_ex_alu_src_b", alu_src_b, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_count", instr_count, 0);
    chk("arst_illegal", illegal_op, 0);
    chk("arst_timeout", mem_timeout, 0);
    chk("arst_alu_src_b", alu_src_b, 0);
    chk("arst_alu_src_a", alu_src_a, 0);
    @(negedge clk);
    #1;
    chk("arst_hold_state", state, 0);
    chk("arst_hold_reg_write", reg_write, 0);
    chk("arst_hold_mem_read", mem_read, 0);
    chk("arst_hold_ir_write", ir_write, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
